decode_prefix_stream: RTL and testbench

// - Sequential prefix scanner between the fetch queue and the opcode decoder.
// - Accepts a window of WINDOW_BYTES instruction bytes per cycle.
// - Strips the leading run of legacy prefixes (F0 F2 F3 2E 36 3E 26 64 65 66 67) and accumulates a prefix summary.
// - The summary is accumulated across as many cycles as needed, up to MAX_PREFIX_BYTES.
// - Reports per cycle how many bytes to pop, then presents the summary via valid/ready once the first non-prefix byte is seen.

---
 rtl/decode_prefix_pkg.sv | 61 ++++++
 rtl/decode_prefix_byte_class.sv | 52 +++++
 rtl/decode_prefix_stream.sv | 181 ++++++++++++++++++
 tb/tb_decode_prefix_stream.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_prefix_pkg.sv
// Shared types for the legacy prefix scanner.
// Prefix byte values, group/kind codes, summary bundle and FSM states.
package decode_prefix_pkg;

  localparam logic [7:0] P_LOCK  = 8'hF0;
  localparam logic [7:0] P_REPNE = 8'hF2;
  localparam logic [7:0] P_REP   = 8'hF3;
  localparam logic [7:0] P_ES    = 8'h26;
  localparam logic [7:0] P_CS    = 8'h2E;
  localparam logic [7:0] P_SS    = 8'h36;
  localparam logic [7:0] P_DS    = 8'h3E;
  localparam logic [7:0] P_FS    = 8'h64;
  localparam logic [7:0] P_GS    = 8'h65;
  localparam logic [7:0] P_OPSZ  = 8'h66;
  localparam logic [7:0] P_ADSZ  = 8'h67;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    SEG_ES = 3'd0,
    SEG_CS = 3'd1,
    SEG_SS = 3'd2,
    SEG_DS = 3'd3,
    SEG_FS = 3'd4,
    SEG_GS = 3'd5
  } seg_index_e;

  typedef enum logic [1:0] {
    GRP_LOCKREP = 2'd0,
    GRP_SEG     = 2'd1,
    GRP_OPSZ    = 2'd2,
    GRP_ADSZ    = 2'd3
  } group_e;

  typedef enum logic [1:0] {
    K_NONE  = 2'd0,
    K_LOCK  = 2'd1,
    K_REPNE = 2'd2,
    K_REP   = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    DONE  = 2'd1,
    ERROR = 2'd2
  } state_e;

  typedef struct packed {
    logic             lock;
    logic             rep_ne;
    logic             rep;
    logic             seg_ovr;
    seg_index_e       seg;
    logic             op_size;
    logic             addr_size;
    logic [CNT_W-1:0] count;
    logic             too_long;
    logic             dup;
  } prefix_summary_t;

endpackage

// File: rtl/decode_prefix_byte_class.sv
// Classifies one instruction byte as a legacy prefix.
// Reports its group, group-1 kind and segment index.
module decode_prefix_byte_class
  import decode_prefix_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_prefix,
  output group_e     o_group,
  output kind_e      o_kind,
  output seg_index_e o_seg_index
);

  always_comb begin
    o_is_prefix = 1'b1;
    o_group     = GRP_LOCKREP;
    o_kind      = K_NONE;
    o_seg_index = SEG_ES;
    unique case (1'b1)
      (i_byte == P_LOCK):  o_kind = K_LOCK;
      (i_byte == P_REPNE): o_kind = K_REPNE;
      (i_byte == P_REP):   o_kind = K_REP;
      (i_byte == P_ES): begin
        o_group     = GRP_SEG;
        o_seg_index = SEG_ES;
      end
      (i_byte == P_CS): begin
        o_group     = GRP_SEG;
        o_seg_index = SEG_CS;
      end
      (i_byte == P_SS): begin
        o_group     = GRP_SEG;
        o_seg_index = SEG_SS;
      end
      (i_byte == P_DS): begin
        o_group     = GRP_SEG;
        o_seg_index = SEG_DS;
      end
      (i_byte == P_FS): begin
        o_group     = GRP_SEG;
        o_seg_index = SEG_FS;
      end
      (i_byte == P_GS): begin
        o_group     = GRP_SEG;
        o_seg_index = SEG_GS;
      end
      (i_byte == P_OPSZ): o_group = GRP_OPSZ;
      (i_byte == P_ADSZ): o_group = GRP_ADSZ;
      default: o_is_prefix = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_prefix_stream.sv
// Legacy prefix scanner: strips leading prefixes, emits a summary.
// Optional PREFIX_DUPLICATE_ERROR_EN flags repeated prefix groups.
module decode_prefix_stream
  import decode_prefix_pkg::*;
#(
  parameter  int WINDOW_BYTES     = 4,
  parameter  int MAX_PREFIX_BYTES = 14,
  localparam int CW = $clog2(WINDOW_BYTES + 1)
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_flush,
  input  logic [WINDOW_BYTES-1:0][7:0] i_window,
  input  logic [CW-1:0]                i_window_count,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [CW-1:0]                o_consume,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_lock,
  output logic                         o_repeat_not_equal,
  output logic                         o_repeat_equal,
  output logic                         o_segment_override,
  output logic [2:0]                   o_segment_index,
  output logic                         o_operand_size,
  output logic                         o_address_size,
  output logic [3:0]                   o_prefix_count,
  output logic                         o_error_too_long,
  output logic                         o_error_duplicate
);

  localparam int AW = 8;

  state_e          r_state;
  state_e          w_state_nxt;
  prefix_summary_t r_sum;
  prefix_summary_t w_sum_nxt;
  prefix_summary_t w_acc;

  logic [WINDOW_BYTES-1:0] w_is_pre;
  group_e                  w_grp [WINDOW_BYTES];
  kind_e                   w_kind [WINDOW_BYTES];
  seg_index_e              w_seg [WINDOW_BYTES];

  logic [AW-1:0] w_run;
  logic [AW-1:0] w_avail;
  logic [AW-1:0] w_take;
  logic          w_stop;
  logic          w_over;
  logic          w_opcode;
  logic          w_accept;

  for (genvar g = 0; g < WINDOW_BYTES; g++) begin : g_cls
    decode_prefix_byte_class u_cls (
      .i_byte      (i_window[g]),
      .o_is_prefix (w_is_pre[g]),
      .o_group     (w_grp[g]),
      .o_kind      (w_kind[g]),
      .o_seg_index (w_seg[g])
    );
  end

  // Leading run of prefixes, clamped to the room left under the limit
  always_comb begin
    w_run  = '0;
    w_stop = 1'b0;
    for (int k = 0; k < WINDOW_BYTES; k++) begin
      if (!w_stop && (CW'(k) < i_window_count) && w_is_pre[k])
        w_run = w_run + AW'(1);
      else
        w_stop = 1'b1;
    end
    w_avail  = AW'(MAX_PREFIX_BYTES) - AW'(r_sum.count);
    w_over   = w_run > w_avail;
    w_take   = w_over ? w_avail : w_run;
    w_opcode = w_run < AW'(i_window_count);
  end

  assign w_accept  = (r_state == SCAN) & i_valid & ~i_flush & ~i_reset;
  assign o_consume = w_accept ? w_take[CW-1:0] : '0;

  always_comb begin
    w_acc = r_sum;
    for (int k = 0; k < WINDOW_BYTES; k++) begin
      if (AW'(k) < w_take) begin
`ifdef PREFIX_DUPLICATE_ERROR_EN
        case (w_grp[k])
          GRP_LOCKREP:
            if (w_acc.lock | w_acc.rep_ne | w_acc.rep)
              w_acc.dup = 1'b1;
          GRP_SEG:  if (w_acc.seg_ovr)   w_acc.dup = 1'b1;
          GRP_OPSZ: if (w_acc.op_size)   w_acc.dup = 1'b1;
          default:  if (w_acc.addr_size) w_acc.dup = 1'b1;
        endcase
`endif
        case (w_grp[k])
          GRP_LOCKREP: begin
            case (w_kind[k])
              K_LOCK:  w_acc.lock = 1'b1;
              K_REPNE: begin
                w_acc.rep_ne = 1'b1;
                w_acc.rep    = 1'b0;
              end
              K_REP: begin
                w_acc.rep    = 1'b1;
                w_acc.rep_ne = 1'b0;
              end
              default: ;
            endcase
          end
          GRP_SEG: begin
            w_acc.seg_ovr = 1'b1;
            w_acc.seg     = w_seg[k];
          end
          GRP_OPSZ: w_acc.op_size   = 1'b1;
          default:  w_acc.addr_size = 1'b1;
        endcase
      end
    end
    w_acc.count = r_sum.count + CNT_W'(w_take);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    if (i_flush) begin
      w_state_nxt = SCAN;
      w_sum_nxt   = '0;
    end else begin
      unique case (r_state)
        SCAN: begin
          if (i_valid) begin
            w_sum_nxt = w_acc;
            if (w_over) begin
              w_state_nxt        = ERROR;
              w_sum_nxt.too_long = 1'b1;
              w_sum_nxt.count    = CNT_W'(MAX_PREFIX_BYTES + 1);
            end else if (w_opcode) begin
              w_state_nxt = DONE;
            end
          end
        end
        DONE, ERROR: begin
          if (i_ready) begin
            w_state_nxt = SCAN;
            w_sum_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = SCAN;
          w_sum_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= SCAN;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sum   <= w_sum_nxt;
    end
  end

  assign o_ready            = (r_state == SCAN);
  assign o_valid            = (r_state != SCAN);
  assign o_lock             = r_sum.lock;
  assign o_repeat_not_equal = r_sum.rep_ne;
  assign o_repeat_equal     = r_sum.rep;
  assign o_segment_override = r_sum.seg_ovr;
  assign o_segment_index    = r_sum.seg;
  assign o_operand_size     = r_sum.op_size;
  assign o_address_size     = r_sum.addr_size;
  assign o_prefix_count     = r_sum.count;
  assign o_error_too_long   = r_sum.too_long;
  // dup is only ever set when duplicate detection is compiled in
  assign o_error_duplicate  = r_sum.dup & o_valid;

endmodule

// File: tb/tb_decode_prefix_stream.sv
// Scoreboard bench for decode_prefix_stream (W=4, limit 14).
// Honours PREFIX_DUPLICATE_ERROR_EN in its reference model.
module tb_decode_prefix_stream;

  logic            clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_flush = 1'b0;
  logic [3:0][7:0] i_window = '0;
  logic [2:0]      i_window_count = '0;
  logic            i_valid = 1'b0;
  logic            i_ready = 1'b0;
  logic            o_ready, o_valid;
  logic [2:0]      o_consume;
  logic            o_lock, o_repeat_not_equal, o_repeat_equal;
  logic            o_segment_override, o_operand_size, o_address_size;
  logic [2:0]      o_segment_index;
  logic [3:0]      o_prefix_count;
  logic            o_error_too_long, o_error_duplicate;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  logic [14:0] exp_q[$];

  always #5 clk = ~clk;

  decode_prefix_stream dut (
    .i_clock            (clk),
    .i_reset            (i_reset),
    .i_flush            (i_flush),
    .i_window           (i_window),
    .i_window_count     (i_window_count),
    .i_valid            (i_valid),
    .o_ready            (o_ready),
    .o_consume          (o_consume),
    .o_valid            (o_valid),
    .i_ready            (i_ready),
    .o_lock             (o_lock),
    .o_repeat_not_equal (o_repeat_not_equal),
    .o_repeat_equal     (o_repeat_equal),
    .o_segment_override (o_segment_override),
    .o_segment_index    (o_segment_index),
    .o_operand_size     (o_operand_size),
    .o_address_size     (o_address_size),
    .o_prefix_count     (o_prefix_count),
    .o_error_too_long   (o_error_too_long),
    .o_error_duplicate  (o_error_duplicate)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_pre(input logic [7:0] b);
    return b inside {8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h36, 8'h3E,
                     8'h26, 8'h64, 8'h65, 8'h66, 8'h67};
  endfunction

  function automatic int seg_of(input logic [7:0] b);
    case (b)
      8'h26:   return 0;
      8'h2E:   return 1;
      8'h36:   return 2;
      8'h3E:   return 3;
      8'h64:   return 4;
      8'h65:   return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] nonpre();
    logic [7:0] b;
    do b = 8'($urandom); while (is_pre(b));
    return b;
  endfunction

  // Summary of a prefix list: only the first 14 bytes are ever taken
  function automatic logic [14:0] model(input logic [7:0] pre[$]);
    int n = (pre.size() > 14) ? 14 : pre.size();
    int grp[4] = '{default: 0};
    int last_rep = -1;
    int last_seg = -1;
    bit lock = 0, op = 0, ad = 0, rne, rep, sov, tl, dup;
    logic [2:0] seg = 3'd0;
    logic [3:0] cnt;
    for (int i = 0; i < n; i++) begin
      if (pre[i] == 8'hF0) begin lock = 1; grp[0]++; end
      if (pre[i] inside {8'hF2, 8'hF3}) begin last_rep = i; grp[0]++; end
      if (seg_of(pre[i]) >= 0) begin last_seg = i; grp[1]++; end
      if (pre[i] == 8'h66) begin op = 1; grp[2]++; end
      if (pre[i] == 8'h67) begin ad = 1; grp[3]++; end
    end
    rne = (last_rep >= 0) && (pre[last_rep] == 8'hF2);
    rep = (last_rep >= 0) && (pre[last_rep] == 8'hF3);
    sov = (last_seg >= 0);
    if (sov) seg = 3'(seg_of(pre[last_seg]));
    tl  = pre.size() > 14;
    cnt = tl ? 4'd15 : 4'(pre.size());
`ifdef PREFIX_DUPLICATE_ERROR_EN
    dup = (grp[0] > 1) || (grp[1] > 1) || (grp[2] > 1) || (grp[3] > 1);
`else
    dup = 0;
`endif
    return {lock, rne, rep, sov, seg, op, ad, cnt, tl, dup};
  endfunction

  // Drive one instruction: prefixes, opcode and trailing bytes
  task automatic run_inst(input logic [7:0] pre[$], input bit full);
    logic [7:0] s[$];
    int pos = 0, taken = 0, guard = 0, cnt, rem, run, lim, ec, hs_tgt;
    bit fin = 0, first = 1;
    s = pre;
    repeat (3) s.push_back(nonpre());
    exp_q.push_back(model(pre));
    hs_tgt = hs_count + 1;
    while (!fin) begin
      @(posedge clk); #1;
      rem = s.size() - pos;
      if (rem > 4) rem = 4;
      cnt = full ? rem : $urandom_range(0, rem);
      i_valid = full ? 1'b1 : ($urandom_range(0, 4) != 0);
      for (int k = 0; k < 4; k++)
        i_window[k] = (k < cnt) ? s[pos + k] : 8'($urandom);
      i_window_count = 3'(cnt);
      @(negedge clk);
      if (first) begin
        chk("start_valid", o_valid, 0);
        chk("start_count", o_prefix_count, 0);
        first = 0;
      end
      if (i_valid) begin
        run = 0;
        while (run < cnt && is_pre(s[pos + run])) run++;
        lim = 14 - taken;
        ec = (run > lim) ? lim : run;
        chk("ready", o_ready, 1);
        chk("consume", o_consume, ec);
        pos += ec;
        taken += ec;
        if (run > lim || run < cnt) fin = 1;
      end
      guard++;
      if (guard > 500) begin
        chk("scan_timeout", 0, 1);
        fin = 1;
      end
    end
    @(posedge clk); #1;
    i_valid = 1'($urandom);
    i_window = 32'($urandom);
    i_window_count = 3'($urandom_range(0, 4));
    guard = 0;
    while (hs_count < hs_tgt && guard < 100) begin
      @(negedge clk); #1;
      chk("idle_consume", o_consume, 0);
      guard++;
    end
    if (hs_count < hs_tgt) chk("hs_timeout", hs_count, hs_tgt);
    i_valid = 1'b0;
  endtask

  // Monitor: holds i_ready low for a while, checks every valid cycle
  initial begin
    int vcyc = 0, wait_n = 0, nsum = 0;
    logic [14:0] act;
    forever begin
      @(posedge clk); #1;
      if (o_valid) begin
        if (vcyc == 0) wait_n = (nsum == 0) ? 5 : $urandom_range(0, 3);
        i_ready = (vcyc >= wait_n);
        vcyc++;
      end else begin
        i_ready = 1'($urandom);
        vcyc = 0;
      end
      @(negedge clk);
      if (o_valid) begin
        act = {o_lock, o_repeat_not_equal, o_repeat_equal,
               o_segment_override, o_segment_index, o_operand_size,
               o_address_size, o_prefix_count, o_error_too_long,
               o_error_duplicate};
        chk("busy_ready", o_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_summary", act, 0);
        end else begin
          chk("summary", act, exp_q[0]);
          if (i_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
            nsum++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    int len;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_consume", o_consume, 0);
    chk("rst_count", o_prefix_count, 0);
    chk("rst_err", {o_error_too_long, o_error_duplicate}, 0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    q = {8'h66, 8'h67};
    run_inst(q, 1);
    q = {8'hF3, 8'h2E, 8'h26, 8'hF2, 8'h3E};
    run_inst(q, 1);
    q = {};
    repeat (15) q.push_back(8'h66);
    run_inst(q, 1);
    q = {8'h66, 8'h66};
    run_inst(q, 1);
    q = {};
    repeat (14) q.push_back(8'h67);
    run_inst(q, 1);

    // flush in the middle of accumulation
    @(posedge clk); #1;
    i_window = {8'h90, 8'h90, 8'h66, 8'hF0};
    i_window_count = 3'd2;
    i_valid = 1'b1;
    @(negedge clk);
    chk("fl_consume0", o_consume, 2);
    @(posedge clk); #1;
    i_flush = 1'b1;
    i_window = {8'h90, 8'h90, 8'h66, 8'h66};
    @(negedge clk);
    chk("fl_consume1", o_consume, 0);
    chk("fl_count_pre", o_prefix_count, 2);
    @(posedge clk); #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk("fl_count", o_prefix_count, 0);
    chk("fl_flags", {o_lock, o_operand_size, o_valid}, 0);
    q = {};
    run_inst(q, 1);

    for (int n = 0; n < 40; n++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 17)
                                        : $urandom_range(0, 5);
      q = {};
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 10))
          0: q.push_back(8'hF0);  1: q.push_back(8'hF2);
          2: q.push_back(8'hF3);  3: q.push_back(8'h2E);
          4: q.push_back(8'h36);  5: q.push_back(8'h3E);
          6: q.push_back(8'h26);  7: q.push_back(8'h64);
          8: q.push_back(8'h65);  9: q.push_back(8'h66);
          default: q.push_back(8'h67);
        endcase
      end
      run_inst(q, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
